// File: rtl/mac_pkg.sv
// Shared definitions for the multi-lane MAC: FSM encoding, parameter legality
// check and the saturation limits derived from the accumulator width.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_OUT
    } mac_state_t;

    localparam int unsigned MAX_ACC_W = 256;

    function automatic bit acc_w_legal(int unsigned width, int unsigned lanes,
                                       int unsigned acc_w);
        return (acc_w >= 2 * width + $clog2(lanes)) && (acc_w <= MAX_ACC_W);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_max(int unsigned acc_w, bit is_signed);
        logic [MAX_ACC_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < acc_w; i++) v[i] = 1'b1;
        if (is_signed) v[acc_w-1] = 1'b0;
        return v;
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_min(int unsigned acc_w, bit is_signed);
        logic [MAX_ACC_W-1:0] v;
        v = '0;
        if (is_signed) v[acc_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mac_dot_stage.sv
// Stage 1 of the MAC: per-lane products summed into a registered dot product,
// with valid and last carried alongside.
module mac_dot_stage
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned SUM_W  = 2 * WIDTH + $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [LANES*WIDTH-1:0] tdata,
    input  logic [LANES*WIDTH-1:0] weight,
    output logic                   s1_valid,
    output logic                   s1_last,
    output logic [SUM_W-1:0]       s1_sum
);

    logic [SUM_W-1:0] lane_ext [LANES];
    logic [SUM_W-1:0] dot_sum;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0]   a, b;
        logic [2*WIDTH-1:0] a_x, b_x, prod;

        assign a = tdata[l*WIDTH +: WIDTH];
        assign b = weight[l*WIDTH +: WIDTH];
        // Operands widened to the product width so the truncated multiply is exact
        assign a_x = (SIGNED != 0) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        assign b_x = (SIGNED != 0) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        assign prod = a_x * b_x;
        assign lane_ext[l] = (SIGNED != 0) ? SUM_W'(signed'(prod)) : SUM_W'(prod);
    end

    always_comb begin
        dot_sum = '0;
        for (int unsigned l = 0; l < LANES; l++) dot_sum = dot_sum + lane_ext[l];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_last  <= in_valid && in_last;
            if (in_valid) s1_sum <= dot_sum;
        end
    end

endmodule

// File: rtl/mac_lanes.sv
// Streaming multi-lane multiply-accumulate: frame FSM, wide accumulator with
// wrap/saturate overflow handling and a held result handshake.
module mac_lanes
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LANES    = 4,
    parameter int unsigned ACC_W    = 80,
    parameter int unsigned SIGNED   = 0,
    parameter int unsigned SATURATE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   tvalid_s,
    input  logic [LANES*WIDTH-1:0] tdata_s,
    input  logic [LANES*WIDTH-1:0] weight_s,
    input  logic                   tlast_s,
    output logic                   tready_s,
    output logic [ACC_W-1:0]       result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   overflow,
    output logic [15:0]            beat_count
);

    localparam int unsigned SUM_W = 2 * WIDTH + $clog2(LANES);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

    if (!acc_w_legal(WIDTH, LANES, ACC_W)) begin : g_bad_acc_w
        $error("mac_lanes: ACC_W too small for WIDTH/LANES");
    end

    mac_state_t       state;
    logic             s1_valid, s1_last, s2_last;
    logic [SUM_W-1:0] s1_sum;
    logic [ACC_W-1:0] acc, acc_next, sum_ext;
    logic [ACC_W:0]   add_full;
    logic             add_ovf;

    mac_dot_stage #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .SIGNED(SIGNED),
        .SUM_W (SUM_W)
    ) u_dot (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(tvalid_s && tready_s),
        .in_last (tlast_s),
        .tdata   (tdata_s),
        .weight  (weight_s),
        .s1_valid(s1_valid),
        .s1_last (s1_last),
        .s1_sum  (s1_sum)
    );

    assign sum_ext  = (SIGNED != 0) ? ACC_W'(signed'(s1_sum)) : ACC_W'(s1_sum);
    assign add_full = {1'b0, acc} + {1'b0, sum_ext};
    assign add_ovf  = (SIGNED != 0)
                    ? (acc[ACC_W-1] == sum_ext[ACC_W-1]) && (add_full[ACC_W-1] != acc[ACC_W-1])
                    : add_full[ACC_W];

    // Once a saturating frame has clamped, the accumulator stays pinned
    always_comb begin
        acc_next = add_full[ACC_W-1:0];
        if (SATURATE != 0) begin
            if (overflow)
                acc_next = acc;
            else if (add_ovf)
                acc_next = ((SIGNED != 0) && acc[ACC_W-1]) ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tready_s     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            beat_count   <= '0;
            acc          <= '0;
            s2_last      <= 1'b0;
        end else begin
            s2_last <= 1'b0;
            if (s1_valid) begin
                acc      <= acc_next;
                overflow <= overflow | add_ovf;
                if (beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
                s2_last  <= s1_last;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        tready_s   <= 1'b1;
                        acc        <= '0;
                        overflow   <= 1'b0;
                        beat_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (tvalid_s && tready_s && tlast_s) begin
                        tready_s <= 1'b0;
                        state    <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (s2_last) begin
                        result       <= acc;
                        result_valid <= 1'b1;
                        state        <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_lanes.sv
// Four mac_lanes configurations share one random stimulus stream and are
// compared against an integer model of the frame arithmetic.
module tb_mac_lanes;

    localparam int W = 8;
    localparam int L = 2;
    localparam int NCFG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start, tvalid_s, tlast_s, result_ready;
    logic [L*W-1:0] tdata_s, weight_s;

    logic        tready [NCFG];
    logic        rv     [NCFG];
    logic        ovf    [NCFG];
    logic [15:0] bc     [NCFG];
    logic [19:0] res    [NCFG];
    logic [19:0] res_u, res_s;
    logic [16:0] res_sat, res_wrap;

    assign res[0] = res_u;
    assign res[1] = res_s;
    assign res[2] = {3'b000, res_sat};
    assign res[3] = {3'b000, res_wrap};

    int cfg_accw [NCFG] = '{20, 20, 17, 17};
    bit cfg_sgn  [NCFG] = '{0, 1, 0, 0};
    bit cfg_sat  [NCFG] = '{0, 0, 1, 0};

    mac_lanes #(.WIDTH(W), .LANES(L), .ACC_W(20), .SIGNED(0), .SATURATE(0)) u_u (
        .clk(clk), .rst_n(rst_n), .start(start), .tvalid_s(tvalid_s), .tdata_s(tdata_s),
        .weight_s(weight_s), .tlast_s(tlast_s), .tready_s(tready[0]), .result(res_u),
        .result_valid(rv[0]), .result_ready(result_ready), .overflow(ovf[0]), .beat_count(bc[0]));
    mac_lanes #(.WIDTH(W), .LANES(L), .ACC_W(20), .SIGNED(1), .SATURATE(0)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start), .tvalid_s(tvalid_s), .tdata_s(tdata_s),
        .weight_s(weight_s), .tlast_s(tlast_s), .tready_s(tready[1]), .result(res_s),
        .result_valid(rv[1]), .result_ready(result_ready), .overflow(ovf[1]), .beat_count(bc[1]));
    mac_lanes #(.WIDTH(W), .LANES(L), .ACC_W(17), .SIGNED(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .tvalid_s(tvalid_s), .tdata_s(tdata_s),
        .weight_s(weight_s), .tlast_s(tlast_s), .tready_s(tready[2]), .result(res_sat),
        .result_valid(rv[2]), .result_ready(result_ready), .overflow(ovf[2]), .beat_count(bc[2]));
    mac_lanes #(.WIDTH(W), .LANES(L), .ACC_W(17), .SIGNED(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .tvalid_s(tvalid_s), .tdata_s(tdata_s),
        .weight_s(weight_s), .tlast_s(tlast_s), .tready_s(tready[3]), .result(res_wrap),
        .result_valid(rv[3]), .result_ready(result_ready), .overflow(ovf[3]), .beat_count(bc[3]));

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] w;
    } beat_t;

    beat_t frame_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint elem(input logic [15:0] v, input int l, input bit sgn);
        logic [7:0] x;
        x = v[l*8 +: 8];
        if (sgn) return longint'($signed(x));
        return longint'(x);
    endfunction

    // Exact frame sum in plain integers, then overflow/clamp/wrap by range rules
    function automatic void model(input int k, output logic [63:0] res_o, output bit ovf_o);
        longint m, lo, hi, acc, s, t;
        m = longint'(1) << cfg_accw[k];
        lo = cfg_sgn[k] ? -(m / 2) : 0;
        hi = cfg_sgn[k] ? (m / 2 - 1) : (m - 1);
        acc = 0;
        ovf_o = 1'b0;
        foreach (frame_q[i]) begin
            s = 0;
            for (int l = 0; l < L; l++)
                s += elem(frame_q[i].d, l, cfg_sgn[k]) * elem(frame_q[i].w, l, cfg_sgn[k]);
            if (!(cfg_sat[k] && ovf_o)) begin
                t = acc + s;
                if (t > hi || t < lo) begin
                    ovf_o = 1'b1;
                    if (cfg_sat[k]) begin
                        acc = (t > hi) ? hi : lo;
                    end else begin
                        t = ((t % m) + m) % m;
                        if (t > hi) t -= m;
                        acc = t;
                    end
                end else begin
                    acc = t;
                end
            end
        end
        res_o = 64'(acc & (m - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("%s_tready%0d", tag, k), 64'(tready[k]), 64'd0);
            check($sformatf("%s_result%0d", tag, k), 64'(res[k]), 64'd0);
            check($sformatf("%s_rvalid%0d", tag, k), 64'(rv[k]), 64'd0);
            check($sformatf("%s_ovf%0d", tag, k), 64'(ovf[k]), 64'd0);
            check($sformatf("%s_beats%0d", tag, k), 64'(bc[k]), 64'd0);
        end
    endtask

    task automatic drive_beat(input beat_t b, input bit last);
        tvalid_s = 1'b1;
        tdata_s  = b.d;
        weight_s = b.w;
        tlast_s  = last;
        check("tready_run", 64'(tready[0]), 64'd1);
        tick();
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int min_gap, input int max_gap,
                             input int hold, input bit start_in_hold, input bit start_with_ready);
        logic [63:0] exp_res [NCFG];
        bit          exp_ovf [NCFG];
        int          lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_tready_start"}, 64'(tready[0]), 64'd1);
        foreach (frame_q[i]) begin
            if (i > 0) repeat ($urandom_range(min_gap, max_gap)) tick();
            drive_beat(frame_q[i], i == frame_q.size() - 1);
        end
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("%s_tready_drop%0d", tag, k), 64'(tready[k]), 64'd0);
            check($sformatf("%s_rv_early%0d", tag, k), 64'(rv[k]), 64'd0);
        end
        lat = 0;
        while (!rv[0] && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_rv_latency"}, 64'(lat), 64'd2);
        for (int k = 0; k < NCFG; k++) begin
            model(k, exp_res[k], exp_ovf[k]);
            check($sformatf("%s_result%0d", tag, k), 64'(res[k]), exp_res[k]);
            check($sformatf("%s_ovf%0d", tag, k), 64'(ovf[k]), 64'(exp_ovf[k]));
            check($sformatf("%s_beats%0d", tag, k), 64'(bc[k]), 64'(frame_q.size()));
            check($sformatf("%s_rvalid%0d", tag, k), 64'(rv[k]), 64'd1);
        end
        for (int j = 0; j < hold; j++) begin
            start = start_in_hold && (j == 2);
            tick();
            start = 1'b0;
            for (int k = 0; k < NCFG; k++) begin
                check($sformatf("%s_hold_rv%0d", tag, k), 64'(rv[k]), 64'd1);
                check($sformatf("%s_hold_res%0d", tag, k), 64'(res[k]), exp_res[k]);
                check($sformatf("%s_hold_ovf%0d", tag, k), 64'(ovf[k]), 64'(exp_ovf[k]));
                check($sformatf("%s_hold_beats%0d", tag, k), 64'(bc[k]), 64'(frame_q.size()));
                check($sformatf("%s_hold_tready%0d", tag, k), 64'(tready[k]), 64'd0);
            end
        end
        result_ready = 1'b1;
        start = start_with_ready;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        check({tag, "_rv_fall"}, 64'(rv[0]), 64'd0);
        check({tag, "_idle_tready"}, 64'(tready[0]), 64'd0);
        tick();
        check({tag, "_idle_tready2"}, 64'(tready[0]), 64'd0);
    endtask

    function automatic beat_t mk(input int d0, input int d1, input int w0, input int w1);
        beat_t b;
        b.d = {8'(d1), 8'(d0)};
        b.w = {8'(w1), 8'(w0)};
        return b;
    endfunction

    task automatic load_frame_a();
        frame_q.delete();
        frame_q.push_back(mk(1, 3, 2, 4));
        frame_q.push_back(mk(5, 7, 6, 8));
        frame_q.push_back(mk(10, 0, 10, 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        tvalid_s = 1'b0;
        tlast_s = 1'b0;
        result_ready = 1'b0;
        tdata_s = '0;
        weight_s = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_outputs("reset");

        load_frame_a();
        check("frame_a_model", 64'(res_expected_u()), 64'd200);
        run_frame("frame_a", 0, 0, 0, 1'b0, 1'b0);

        load_frame_a();
        run_frame("frame_gaps", 1, 3, 5, 1'b1, 1'b1);

        frame_q.delete();
        frame_q.push_back(mk(-3, 2, 5, -4));
        run_frame("signed", 0, 0, 1, 1'b0, 1'b0);
        check("signed_value", 64'(res[1]), 64'hFFFE9);

        frame_q.delete();
        frame_q.push_back(mk(255, 255, 255, 255));
        frame_q.push_back(mk(255, 255, 255, 255));
        run_frame("ovf17", 0, 0, 0, 1'b0, 1'b0);
        check("sat_value", 64'(res[2]), 64'h1FFFF);
        check("wrap_value", 64'(res[3]), 64'd129028);

        // Abort mid-frame: two beats in flight, then one reset cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_beat(mk(200, 200, 200, 200), 1'b0);
        drive_beat(mk(100, 50, 90, 70), 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("abort");
        frame_q.delete();
        frame_q.push_back(mk(2, 3, 4, 5));
        run_frame("after_abort", 0, 0, 0, 1'b0, 1'b0);
        check("after_abort_value", 64'(res[0]), 64'd23);

        for (int f = 0; f < 10; f++) begin
            frame_q.delete();
            repeat ($urandom_range(1, 8))
                frame_q.push_back(mk($urandom_range(0, 255), $urandom_range(0, 255),
                                     $urandom_range(0, 255), $urandom_range(0, 255)));
            run_frame($sformatf("rand%0d", f), 0, $urandom_range(0, 2), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic longint res_expected_u();
        logic [63:0] r;
        bit          o;
        model(0, r, o);
        return longint'(r);
    endfunction

endmodule
